// File: rtl/rv32_instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscy_pkg
// Purpose  : Shared types and constants for the RV32I instruction encoder:
//            instruction format enum, base opcodes, the canonical NOP and the
//            signed immediate ranges each format can carry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package riscy_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -(1 << 20);
    localparam int IMM_J_MAX = (1 << 20) - 2;

    function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_imm_pack.sv
`default_nettype none
// ============================================================================
// Module   : rv32_imm_pack
// Purpose  : Combinational immediate scatter for RV32I. Places the immediate
//            (and the R/I-shift funct7 bit) into its instruction bit slots,
//            flags whether the immediate is representable, and reports which
//            register/funct3 fields the format uses.
// Ports    : i_fmt, i_funct3, i_funct7, i_imm  -> field selection inputs
//            o_imm_bits  immediate bits already at their instruction position
//            o_legal     bundle is encodable
//            o_use_*     rd / rs1 / rs2 / funct3 fields present in the format
// Revision : 1.0 - initial release
// ============================================================================
module rv32_imm_pack
    import riscy_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_imm_bits,
    output logic        o_legal,
    output logic        o_use_rd,
    output logic        o_use_rs1,
    output logic        o_use_rs2,
    output logic        o_use_f3
);

    logic w_shift;

    // slli / srli / srai: the upper immediate slot carries funct7, not a value
    assign w_shift = (i_funct3 == 3'd1) || (i_funct3 == 3'd5);

    always_comb begin
        o_imm_bits = 32'h0;
        o_legal    = 1'b0;
        o_use_rd   = 1'b0;
        o_use_rs1  = 1'b0;
        o_use_rs2  = 1'b0;
        o_use_f3   = 1'b0;
        case (i_fmt)
            FMT_R: begin
                o_imm_bits[30] = i_funct7;
                o_legal        = 1'b1;
                o_use_rd       = 1'b1;
                o_use_rs1      = 1'b1;
                o_use_rs2      = 1'b1;
                o_use_f3       = 1'b1;
            end
            FMT_I: begin
                if (w_shift) begin
                    o_imm_bits[31:20] = {1'b0, i_funct7, 5'b0, i_imm[4:0]};
                    o_legal           = (i_imm[31:5] == 27'h0);
                end else begin
                    o_imm_bits[31:20] = i_imm[11:0];
                    o_legal           = imm_in_range(i_imm, IMM_I_MIN, IMM_I_MAX);
                end
                o_use_rd  = 1'b1;
                o_use_rs1 = 1'b1;
                o_use_f3  = 1'b1;
            end
            FMT_S: begin
                o_imm_bits[31:25] = i_imm[11:5];
                o_imm_bits[11:7]  = i_imm[4:0];
                o_legal           = imm_in_range(i_imm, IMM_I_MIN, IMM_I_MAX);
                o_use_rs1         = 1'b1;
                o_use_rs2         = 1'b1;
                o_use_f3          = 1'b1;
            end
            FMT_B: begin
                o_imm_bits[31]    = i_imm[12];
                o_imm_bits[30:25] = i_imm[10:5];
                o_imm_bits[11:8]  = i_imm[4:1];
                o_imm_bits[7]     = i_imm[11];
                o_legal           = imm_in_range(i_imm, IMM_B_MIN, IMM_B_MAX) && !i_imm[0];
                o_use_rs1         = 1'b1;
                o_use_rs2         = 1'b1;
                o_use_f3          = 1'b1;
            end
            FMT_U: begin
                o_imm_bits[31:12] = i_imm[31:12];
                o_legal           = (i_imm[11:0] == 12'h0);
                o_use_rd          = 1'b1;
            end
            FMT_J: begin
                o_imm_bits[31]    = i_imm[20];
                o_imm_bits[30:21] = i_imm[10:1];
                o_imm_bits[20]    = i_imm[11];
                o_imm_bits[19:12] = i_imm[19:12];
                o_legal           = imm_in_range(i_imm, IMM_J_MIN, IMM_J_MAX) && !i_imm[0];
                o_use_rd          = 1'b1;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv32_instr_encoder
// Purpose  : Packs RV32I field bundles into 32-bit instruction words with a
//            byte-address tag. One output register stage, valid/ready on both
//            sides, one word per cycle. Unencodable bundles become a NOP with
//            out_err set and latch err_sticky.
// Ports    : clk, rst_n                  clock, async active-low reset
//            in_valid/in_ready + in_*    field bundle input
//            out_valid/out_ready         encoded word handshake
//            out_instr, out_addr, out_err encoded word, address, illegal flag
//            addr_load, addr_base        reload of the next-word address
//            err_sticky, err_clr         sticky illegal-bundle flag
//            word_cnt                    output handshakes since reset
// Revision : 1.0 - initial release
// ============================================================================
module rv32_instr_encoder
    import riscy_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_base,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic [15:0]       word_cnt
);

    localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(4);

    logic              r_valid_q,     w_valid_d;
    logic [31:0]       r_instr_q,     w_instr_d;
    logic [ADDR_W-1:0] r_addr_q,      w_addr_d;
    logic              r_err_q,       w_err_d;
    logic              r_sticky_q,    w_sticky_d;
    logic [15:0]       r_cnt_q,       w_cnt_d;
    logic [ADDR_W-1:0] r_next_addr_q, w_next_addr_d;

    logic        w_accept;
    logic        w_out_hs;
    logic [31:0] w_imm_bits;
    logic        w_legal;
    logic        w_use_rd;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_use_f3;
    logic [31:0] w_word;

    rv32_imm_pack u_imm_pack (
        .i_fmt      (in_fmt),
        .i_funct3   (in_funct3),
        .i_funct7   (in_funct7),
        .i_imm      (in_imm),
        .o_imm_bits (w_imm_bits),
        .o_legal    (w_legal),
        .o_use_rd   (w_use_rd),
        .o_use_rs1  (w_use_rs1),
        .o_use_rs2  (w_use_rs2),
        .o_use_f3   (w_use_f3)
    );

    assign in_ready = !r_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = r_valid_q && out_ready;

    // Register fields never overlap the immediate slots of the formats that use them
    assign w_word = w_imm_bits | {7'b0,
                                  w_use_rs2 ? in_rs2    : 5'b0,
                                  w_use_rs1 ? in_rs1    : 5'b0,
                                  w_use_f3  ? in_funct3 : 3'b0,
                                  w_use_rd  ? in_rd     : 5'b0,
                                  in_op};

    always_comb begin
        w_valid_d     = r_valid_q;
        w_instr_d     = r_instr_q;
        w_addr_d      = r_addr_q;
        w_err_d       = r_err_q;
        w_sticky_d    = r_sticky_q;
        w_cnt_d       = r_cnt_q;
        w_next_addr_d = r_next_addr_q;

        if (w_out_hs) begin
            w_valid_d = 1'b0;
            w_cnt_d   = r_cnt_q + 16'd1;
        end

        if (w_accept) begin
            w_valid_d = 1'b1;
            w_instr_d = w_legal ? w_word : NOP_INSTR;
            w_err_d   = !w_legal;
            w_addr_d  = r_next_addr_q;
        end

        // The address step is taken when a word is tagged rather than when it
        // leaves: every tagged word leaves by handshake (or is wiped by reset),
        // so the sequence is identical, a back-to-back accept gets the stepped
        // address without a bypass, and a reload during a hold is not stepped
        // past by the held word's later handshake.
        if (addr_load) begin
            w_next_addr_d = addr_base;
        end else if (w_accept) begin
            w_next_addr_d = r_next_addr_q + c_ADDR_STEP;
        end

        // A new illegal bundle beats a simultaneous clear
        if (w_accept && !w_legal) begin
            w_sticky_d = 1'b1;
        end else if (err_clr) begin
            w_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q     <= 1'b0;
            r_instr_q     <= 32'h0;
            r_addr_q      <= RESET_ADDR;
            r_err_q       <= 1'b0;
            r_sticky_q    <= 1'b0;
            r_cnt_q       <= 16'h0;
            r_next_addr_q <= RESET_ADDR;
        end else begin
            r_valid_q     <= w_valid_d;
            r_instr_q     <= w_instr_d;
            r_addr_q      <= w_addr_d;
            r_err_q       <= w_err_d;
            r_sticky_q    <= w_sticky_d;
            r_cnt_q       <= w_cnt_d;
            r_next_addr_q <= w_next_addr_d;
        end
    end

    assign out_valid  = r_valid_q;
    assign out_instr  = r_instr_q;
    assign out_addr   = r_addr_q;
    assign out_err    = r_err_q;
    assign err_sticky = r_sticky_q;
    assign word_cnt   = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_instr_encoder
// Purpose  : Directed self-checking bench for rv32_instr_encoder: encodings
//            of every format, legality boundaries, backpressure, address
//            reload and wrap, sticky error and reset while a word is held.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_op;
    logic [2:0]  in_funct3;
    logic        in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic        addr_load;
    logic [31:0] addr_base;
    logic        err_sticky;
    logic        err_clr;
    logic [15:0] word_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_words  = 0;
    logic [31:0] exp_addr = 32'h0;

    always #5 clk = ~clk;

    rv32_instr_encoder #(
        .ADDR_W     (32),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_op      (in_op),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .addr_load  (addr_load),
        .addr_base  (addr_base),
        .err_sticky (err_sticky),
        .err_clr    (err_clr),
        .word_cnt   (word_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        in_fmt    = fmt;
        in_op     = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    // Caller guarantees in_ready (output empty or out_ready high)
    task automatic push(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        drive(fmt, op, f3, f7, rd, rs1, rs2, imm);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_words++;
    endtask

    task automatic push_chk(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                            input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                            input logic [31:0] exp_instr, input logic exp_err);
        push(fmt, op, f3, f7, rd, rs1, rs2, imm);
        chk(tag, out_instr, exp_instr);
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
        chk({tag, "_addr"}, out_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        addr_load = 1'b0;
        addr_base = 32'h0;
        err_clr   = 1'b0;
        drive(3'd0, 7'h0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  32'(out_valid),  32'h0);
        chk("rst_instr",  out_instr,       32'h0);
        chk("rst_addr",   out_addr,        32'h0);
        chk("rst_err",    32'(out_err),    32'h0);
        chk("rst_sticky", 32'(err_sticky), 32'h0);
        chk("rst_cnt",    32'(word_cnt),   32'h0);
        rst_n = 1'b1;

        // Encodings and legality boundaries, streaming with out_ready high
        push_chk("r_add",     3'd0, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0,        32'h002081B3, 1'b0);
        push_chk("i_addi",    3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        push_chk("s_sw",      3'd2, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'h8,        32'h0020A423, 1'b0);
        push_chk("u_lui",     3'd4, 7'h37, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
        push_chk("b_beq",     3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        push_chk("j_jal",     3'd5, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800,      32'h001000EF, 1'b0);
        chk("sticky_clean", 32'(err_sticky), 32'h0);
        push_chk("b_odd",     3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h3,        32'h00000013, 1'b1);
        chk("sticky_set", 32'(err_sticky), 32'h1);
        push_chk("i_slli",    3'd1, 7'h13, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'h5,        32'h00509093, 1'b0);
        push_chk("i_srai",    3'd1, 7'h13, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'h3,        32'h4030D093, 1'b0);
        push_chk("i_shamt32", 3'd1, 7'h13, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32,       32'h00000013, 1'b1);
        push_chk("i_imm2048", 3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h00000013, 1'b1);
        push_chk("i_immmin",  3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
        push_chk("b_max",     3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4094,     32'h7E000FE3, 1'b0);
        push_chk("b_4096",    3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096,     32'h00000013, 1'b1);
        push_chk("j_max",     3'd5, 7'h6F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h000FFFFE, 32'h7FFFF06F, 1'b0);
        push_chk("u_low",     3'd4, 7'h37, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h00000013, 1'b1);
        push_chk("fmt6",      3'd6, 7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h00000013, 1'b1);
        idle_cycle();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("cnt_stream",  32'(word_cnt),  32'(n_words));

        // Sticky clear, then set-and-clear in the same cycle
        err_clr = 1'b1;
        idle_cycle();
        err_clr = 1'b0;
        chk("sticky_clr", 32'(err_sticky), 32'h0);
        err_clr = 1'b1;
        push_chk("fmt7_clr",  3'd7, 7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h00000013, 1'b1);
        err_clr = 1'b0;
        chk("sticky_set_wins", 32'(err_sticky), 32'h1);

        // Backpressure: four back-to-back bundles, out_ready low in cycles 2-4
        addr_load = 1'b1;
        addr_base = 32'h0;
        idle_cycle();
        addr_load = 1'b0;
        begin
            int          sent     = 0;
            int          got      = 0;
            logic        was_held = 1'b0;
            logic [31:0] held_instr = 32'h0;
            logic        acc;
            for (int c = 0; c < 20 && got < 4; c++) begin
                if (sent < 4) drive(3'd1, 7'h13, 3'd0, 1'b0, 5'(sent + 1), 5'd0, 5'd0, 32'(sent));
                else          in_valid = 1'b0;
                out_ready = !(c >= 2 && c <= 4);
                #4;
                if (out_valid && !out_ready) chk("bp_in_ready", 32'(in_ready), 32'h0);
                if (was_held) chk("bp_stable", out_instr, held_instr);
                if (out_valid && out_ready) begin
                    chk("bp_instr", out_instr, (32'(got) << 20) | (32'(got + 1) << 7) | 32'h13);
                    chk("bp_addr",  out_addr,  32'(got * 4));
                    got++;
                end
                was_held   = out_valid && !out_ready;
                held_instr = out_instr;
                acc        = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (acc) begin
                    sent++;
                    n_words++;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("bp_count", 32'(got), 32'h4);
            chk("bp_empty", 32'(out_valid), 32'h0);
            chk("bp_cnt",   32'(word_cnt), 32'(n_words));
        end

        // Address reload while a word is held, then wrap past the top
        addr_load = 1'b1;
        addr_base = 32'h8;
        idle_cycle();
        addr_load = 1'b0;
        out_ready = 1'b0;
        push(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1);
        chk("hold_addr", out_addr, 32'h8);
        addr_load = 1'b1;
        addr_base = 32'h100;
        @(posedge clk);
        #1;
        addr_load = 1'b0;
        chk("hold_valid",     32'(out_valid), 32'h1);
        chk("hold_addr_kept", out_addr,       32'h8);
        out_ready = 1'b1;
        exp_addr  = 32'h100;
        push_chk("after_load", 3'd0, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0);
        addr_load = 1'b1;
        addr_base = 32'hFFFFFFFC;
        idle_cycle();
        addr_load = 1'b0;
        exp_addr  = 32'hFFFFFFFC;
        push_chk("wrap_top",  3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1, 32'h00100093, 1'b0);
        push_chk("wrap_zero", 3'd1, 7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h2, 32'h00200113, 1'b0);
        idle_cycle();
        chk("cnt_final", 32'(word_cnt), 32'(n_words));

        // Reset while an illegal word is held
        out_ready = 1'b0;
        push(3'd7, 7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        chk("pre_rst_valid",  32'(out_valid),  32'h1);
        chk("pre_rst_sticky", 32'(err_sticky), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(out_valid),  32'h0);
        chk("mid_rst_addr",   out_addr,        32'h0);
        chk("mid_rst_cnt",    32'(word_cnt),   32'h0);
        chk("mid_rst_sticky", 32'(err_sticky), 32'h0);
        chk("mid_rst_instr",  out_instr,       32'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        n_words   = 0;
        exp_addr  = 32'h0;
        push_chk("post_rst", 3'd0, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0);
        idle_cycle();
        chk("post_rst_cnt", 32'(word_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
